// File: rtl/down_counter_timer.sv
// Loadable modulo-MOD down counter with a one-cycle borrow pulse.
// Borrow either reloads to MOD-1 and keeps running, or parks the counter in EXPIRED.
module down_counter_timer #(
   parameter int WIDTH = 2,
   parameter int MOD   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             auto_reload,
   input  logic             x,
   output logic [WIDTH-1:0] Q,
   output logic             z,
   output logic             busy,
   output logic             expired
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      EXPIRED = 2'b10
   } stateT;

   localparam logic [WIDTH-1:0] QMAX = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   stateT            state;
   stateT            stateNext;
   logic [WIDTH-1:0] qNext;
   logic             zNext;
   logic [WIDTH-1:0] loadSat;

   // Start values beyond the modulus clamp to the top count.
   assign loadSat = (load_val > QMAX) ? QMAX : load_val;

   // Next-state, next-count and borrow decode; clear beats load beats x.
   always_comb begin
      stateNext = state;
      qNext     = Q;
      zNext     = 1'b0;
      if (clear) begin
         stateNext = IDLE;
         qNext     = '0;
      end else if (load) begin
         stateNext = RUN;
         qNext     = loadSat;
      end else begin
         case (state)
            IDLE: begin
               stateNext = IDLE;
            end
            RUN: begin
               if (x) begin
                  if (Q == '0) begin
                     zNext = 1'b1;
                     if (auto_reload) begin
                        qNext = QMAX;
                     end else begin
                        stateNext = EXPIRED;
                     end
                  end else begin
                     qNext = Q - ONE;
                  end
               end
            end
            EXPIRED: begin
               stateNext = EXPIRED;
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end
   end

   // State, count and borrow registers; reset aborts everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         Q     <= '0;
         z     <= 1'b0;
      end else begin
         state <= stateNext;
         Q     <= qNext;
         z     <= zNext;
      end
   end

   assign busy    = (state == RUN);
   assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: vector table on a MOD=4 instance,
// plus hand sequences for async reset, a MOD=3 instance and a two-digit cascade.
module tb_down_counter_timer;

   logic clk;
   logic reset;

   logic       clear, load, autoReload, x;
   logic [1:0] loadVal;
   logic [1:0] q;
   logic       z, busy, expired;

   logic       m3Clear, m3Load, m3AutoReload, m3X;
   logic [1:0] m3LoadVal;
   logic [1:0] m3Q;
   logic       m3Z, m3Busy, m3Expired;

   logic       cClear, cLoad, cX;
   logic [1:0] loLoadVal, hiLoadVal;
   logic [1:0] loQ, hiQ;
   logic       loZ, hiZ, loBusy, hiBusy, loExpired, hiExpired;

   int testsRun;
   int failures;

   typedef struct packed {
      logic       clear;
      logic       load;
      logic [1:0] loadVal;
      logic       autoReload;
      logic       x;
      logic [1:0] expQ;
      logic       expZ;
      logic       expBusy;
      logic       expExpired;
   } vecT;

   localparam int NVEC = 21;
   vecT vecs [NVEC];

   down_counter_timer #(.WIDTH(2), .MOD(4)) dut (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(loadVal),
      .auto_reload(autoReload), .x(x), .Q(q), .z(z), .busy(busy), .expired(expired)
   );

   down_counter_timer #(.WIDTH(2), .MOD(3)) dutMod3 (
      .clk(clk), .reset(reset), .clear(m3Clear), .load(m3Load), .load_val(m3LoadVal),
      .auto_reload(m3AutoReload), .x(m3X), .Q(m3Q), .z(m3Z), .busy(m3Busy),
      .expired(m3Expired)
   );

   down_counter_timer #(.WIDTH(2), .MOD(4)) dutLo (
      .clk(clk), .reset(reset), .clear(cClear), .load(cLoad), .load_val(loLoadVal),
      .auto_reload(1'b1), .x(cX), .Q(loQ), .z(loZ), .busy(loBusy), .expired(loExpired)
   );

   down_counter_timer #(.WIDTH(2), .MOD(4)) dutHi (
      .clk(clk), .reset(reset), .clear(cClear), .load(cLoad), .load_val(hiLoadVal),
      .auto_reload(1'b0), .x(loZ), .Q(hiQ), .z(hiZ), .busy(hiBusy), .expired(hiExpired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Inputs change just after a falling edge; outputs are read at the next falling edge.
   task automatic stepCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input vecT v);
      clear      = v.clear;
      load       = v.load;
      loadVal    = v.loadVal;
      autoReload = v.autoReload;
      x          = v.x;
      stepCycle();
   endtask

   task automatic checkMain(input string tag, input logic [1:0] eq, input logic ez,
                            input logic eb, input logic ee);
      checkOutput({tag, ".Q"}, 32'(q), 32'(eq));
      checkOutput({tag, ".z"}, 32'(z), 32'(ez));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(eb));
      checkOutput({tag, ".expired"}, 32'(expired), 32'(ee));
   endtask

   // Hand-computed cascade expectations after each of seven x=1 edges.
   logic [1:0] expHiQ   [7] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
   logic       expHiZ   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic       expHiExp [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic       expLoZ   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic [1:0] expLoQ   [7] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};

   initial begin
      testsRun = 0;
      failures = 0;

      //           clr  ld  lv    ar   x    Q     z    busy exp
      vecs[0]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};

      clear = 0; load = 0; loadVal = 0; autoReload = 0; x = 0;
      m3Clear = 0; m3Load = 0; m3LoadVal = 0; m3AutoReload = 0; m3X = 0;
      cClear = 0; cLoad = 0; cX = 0; loLoadVal = 0; hiLoadVal = 0;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkMain("reset", 2'd0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         checkMain($sformatf("vec%0d", i), vecs[i].expQ, vecs[i].expZ,
                   vecs[i].expBusy, vecs[i].expExpired);
      end

      // Async reset mid-count at Q=2, observed before any clock edge.
      applyStimulus('{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0});
      applyStimulus('{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0});
      checkMain("preReset", 2'd2, 1'b0, 1'b1, 1'b0);
      #1 reset = 1'b0;
      #1 checkMain("asyncReset", 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Async reset while a borrow pulse is in flight.
      applyStimulus('{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0});
      applyStimulus('{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1});
      checkMain("zBeforeReset", 2'd0, 1'b1, 1'b0, 1'b1);
      #1 reset = 1'b0;
      #1 checkMain("zReset", 2'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      x = 1'b0;

      // Modulus-3 instance: saturation on load and wrap to 2, never 3.
      m3Load = 1'b1; m3LoadVal = 2'd3; m3AutoReload = 1'b1;
      stepCycle();
      checkOutput("mod3.sat", 32'(m3Q), 32'd2);
      m3Load = 1'b0; m3X = 1'b1;
      stepCycle();
      checkOutput("mod3.dec1", 32'(m3Q), 32'd1);
      stepCycle();
      checkOutput("mod3.dec0", 32'(m3Q), 32'd0);
      stepCycle();
      checkOutput("mod3.wrapQ", 32'(m3Q), 32'd2);
      checkOutput("mod3.wrapZ", 32'(m3Z), 32'd1);
      checkOutput("mod3.busy", 32'(m3Busy), 32'd1);
      stepCycle();
      checkOutput("mod3.afterQ", 32'(m3Q), 32'd1);
      checkOutput("mod3.afterZ", 32'(m3Z), 32'd0);
      m3X = 1'b0;

      // Two-digit cascade: low 0 / high 1, low reloads, high expires.
      cLoad = 1'b1; loLoadVal = 2'd0; hiLoadVal = 2'd1;
      stepCycle();
      checkOutput("casc.loadLo", 32'(loQ), 32'd0);
      checkOutput("casc.loadHi", 32'(hiQ), 32'd1);
      cLoad = 1'b0; cX = 1'b1;
      for (int i = 0; i < 7; i++) begin
         stepCycle();
         checkOutput($sformatf("casc%0d.loQ", i), 32'(loQ), 32'(expLoQ[i]));
         checkOutput($sformatf("casc%0d.loZ", i), 32'(loZ), 32'(expLoZ[i]));
         checkOutput($sformatf("casc%0d.hiQ", i), 32'(hiQ), 32'(expHiQ[i]));
         checkOutput($sformatf("casc%0d.hiZ", i), 32'(hiZ), 32'(expHiZ[i]));
         checkOutput($sformatf("casc%0d.hiExp", i), 32'(hiExpired), 32'(expHiExp[i]));
      end
      cX = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule
